// File: rtl/onehot_event_encoder_if.sv
// Event/code port bundle for onehot_event_encoder.
// The master modport is the encoder side; the slave modport is the event source and code consumer.
interface onehot_event_encoder_if;
    logic [7:0] req_in;
    logic [2:0] code_out;
    logic       valid_out;
    logic       ready_in;
    logic [7:0] pending_out;
    logic       overflow_out;

    modport master (
        input  req_in,
        input  ready_in,
        output code_out,
        output valid_out,
        output pending_out,
        output overflow_out
    );

    modport slave (
        output req_in,
        output ready_in,
        input  code_out,
        input  valid_out,
        input  pending_out,
        input  overflow_out
    );
endinterface

// File: rtl/onehot_event_encoder.sv
// Serializing 8-to-3 event encoder: sticky pending events are issued one per cycle
// as 3-bit codes on a valid/ready port. Fixed priority or round-robin selection.
module onehot_event_encoder #(
    parameter bit RR_MODE = 1'b0
) (
    input logic                    clk,
    input logic                    rst,
    onehot_event_encoder_if.master bus
);
    logic [7:0] pending;
    logic [2:0] code_r;
    logic       valid_r;
    logic       ovf_r;
    logic [2:0] last;

    logic [2:0] sel;
    logic [2:0] cand;
    logic       load;
    logic       take;
    logic [7:0] clear_mask;

    // Scan order is arranged so the preferred candidate is written last and wins.
    always_comb begin
        sel  = 3'd0;
        cand = 3'd0;
        if (RR_MODE) begin
            for (int k = 7; k >= 0; k--) begin
                cand = last + 3'(k) + 3'd1;
                if (pending[cand]) sel = cand;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (pending[i]) sel = 3'(i);
            end
        end
    end

    assign load       = !valid_r || bus.ready_in;
    assign take       = load && (|pending);
    assign clear_mask = take ? (8'd1 << sel) : 8'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 8'd0;
            code_r  <= 3'd0;
            valid_r <= 1'b0;
            ovf_r   <= 1'b0;
            last    <= 3'd7;
        end else begin
            // A request landing on its own clear edge re-arms the bit; it is not lost.
            pending <= (pending & ~clear_mask) | bus.req_in;
            ovf_r   <= |(bus.req_in & pending & ~clear_mask);
            if (take) begin
                code_r  <= sel;
                valid_r <= 1'b1;
                if (RR_MODE) last <= sel;
            end else if (load) begin
                valid_r <= 1'b0;
            end
        end
    end

    assign bus.code_out     = code_r;
    assign bus.valid_out    = valid_r;
    assign bus.pending_out  = pending;
    assign bus.overflow_out = ovf_r;
endmodule

// File: tb/tb_onehot_event_encoder.sv
// Self-checking bench: directed tables and sequences, then random traffic against a reference model.
module tb_onehot_event_encoder;
    logic clk;
    logic rst;

    onehot_event_encoder_if bus0 ();
    onehot_event_encoder_if bus1 ();

    onehot_event_encoder #(.RR_MODE(1'b0)) dut_fixed (.clk(clk), .rst(rst), .bus(bus0.master));
    onehot_event_encoder #(.RR_MODE(1'b1)) dut_rr    (.clk(clk), .rst(rst), .bus(bus1.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] req;
        logic       ready;
        logic [2:0] code;
        logic       valid;
        logic [7:0] pend;
        logic       ovf;
    } vec_t;

    vec_t vecs[17];

    // Reference model state, index 0 = fixed priority, 1 = round-robin.
    logic [7:0] m_pend[2];
    logic [2:0] m_code[2];
    logic       m_valid[2];
    logic       m_ovf[2];
    int         m_last[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input int m, input logic [2:0] code,
                             input logic valid, input logic [7:0] pend, input logic ovf);
        if (m == 0) begin
            check({tag, " code"},  8'(bus0.code_out),     8'(code));
            check({tag, " valid"}, 8'(bus0.valid_out),    8'(valid));
            check({tag, " pend"},  bus0.pending_out,      pend);
            check({tag, " ovf"},   8'(bus0.overflow_out), 8'(ovf));
        end else begin
            check({tag, " code"},  8'(bus1.code_out),     8'(code));
            check({tag, " valid"}, 8'(bus1.valid_out),    8'(valid));
            check({tag, " pend"},  bus1.pending_out,      pend);
            check({tag, " ovf"},   8'(bus1.overflow_out), 8'(ovf));
        end
    endtask

    function automatic int pick(input int mode, input logic [7:0] p, input int lst);
        if (mode == 0) begin
            for (int i = 7; i >= 0; i--) if (p[i]) return i;
        end else begin
            for (int off = 1; off <= 8; off++) if (p[(lst + off) % 8]) return (lst + off) % 8;
        end
        return -1;
    endfunction

    // Advance the model across one clock edge given the inputs presented before it.
    task automatic model_step(input int m, input logic [7:0] req, input logic ready, input logic r);
        int s;
        logic [7:0] remaining;
        if (r) begin
            m_pend[m] = 8'h00; m_code[m] = 3'd0; m_valid[m] = 1'b0; m_ovf[m] = 1'b0; m_last[m] = 7;
            return;
        end
        remaining = m_pend[m];
        if (!m_valid[m] || ready) begin
            s = pick(m, m_pend[m], m_last[m]);
            if (s >= 0) begin
                m_code[m]  = 3'(s);
                m_valid[m] = 1'b1;
                m_last[m]  = s;
                remaining[s] = 1'b0;
            end else begin
                m_valid[m] = 1'b0;
            end
        end
        m_ovf[m]  = (req & remaining) != 8'h00;
        m_pend[m] = remaining | req;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{8'hA5, 1'b1, 3'd0, 1'b0, 8'hA5, 1'b0};
        vecs[1]  = '{8'h00, 1'b1, 3'd7, 1'b1, 8'h25, 1'b0};
        vecs[2]  = '{8'h00, 1'b1, 3'd5, 1'b1, 8'h05, 1'b0};
        vecs[3]  = '{8'h00, 1'b1, 3'd2, 1'b1, 8'h01, 1'b0};
        vecs[4]  = '{8'h00, 1'b1, 3'd0, 1'b1, 8'h00, 1'b0};
        vecs[5]  = '{8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0};
        vecs[6]  = '{8'hA5, 1'b0, 3'd0, 1'b0, 8'hA5, 1'b0};
        vecs[7]  = '{8'h00, 1'b0, 3'd7, 1'b1, 8'h25, 1'b0};
        for (int i = 8; i <= 12; i++) vecs[i] = '{8'h00, 1'b0, 3'd7, 1'b1, 8'h25, 1'b0};
        vecs[13] = '{8'h00, 1'b1, 3'd5, 1'b1, 8'h05, 1'b0};
        vecs[14] = '{8'h00, 1'b1, 3'd2, 1'b1, 8'h01, 1'b0};
        vecs[15] = '{8'h00, 1'b1, 3'd0, 1'b1, 8'h00, 1'b0};
        vecs[16] = '{8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0};

        // Reset held two cycles with all events asserted.
        rst = 1'b1;
        bus0.req_in = 8'hFF; bus0.ready_in = 1'b1;
        bus1.req_in = 8'hFF; bus1.ready_in = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bus0.req_in = 8'h00;
        bus1.req_in = 8'h00;
        check_all("reset0", 0, 3'd0, 1'b0, 8'h00, 1'b0);
        check_all("reset1", 1, 3'd0, 1'b0, 8'h00, 1'b0);

        // Fixed-priority burst followed by the same burst under backpressure.
        for (int i = 0; i < 17; i++) begin
            bus0.req_in   = vecs[i].req;
            bus0.ready_in = vecs[i].ready;
            tick();
            check_all($sformatf("vec%0d", i), 0, vecs[i].code, vecs[i].valid, vecs[i].pend, vecs[i].ovf);
        end
        bus0.req_in = 8'h00;

        // Overflow: hold the output busy with code 6, then pulse event 3 twice.
        bus0.ready_in = 1'b0;
        bus0.req_in = 8'h40; tick();
        bus0.req_in = 8'h00; tick();
        check_all("ovf_busy", 0, 3'd6, 1'b1, 8'h00, 1'b0);
        bus0.req_in = 8'h08; tick();
        check_all("ovf_first", 0, 3'd6, 1'b1, 8'h08, 1'b0);
        bus0.req_in = 8'h00; tick(); tick();
        bus0.req_in = 8'h08; tick();
        check_all("ovf_second", 0, 3'd6, 1'b1, 8'h08, 1'b1);
        bus0.req_in = 8'h00; tick();
        check_all("ovf_pulse_end", 0, 3'd6, 1'b1, 8'h08, 1'b0);
        bus0.ready_in = 1'b1; tick();
        check_all("ovf_code3", 0, 3'd3, 1'b1, 8'h00, 1'b0);
        tick();
        check_all("ovf_single3", 0, 3'd3, 1'b0, 8'h00, 1'b0);

        // Clear/set collision on event 4.
        bus0.req_in = 8'h10; tick();
        bus0.req_in = 8'h10; tick();
        check_all("coll_first4", 0, 3'd4, 1'b1, 8'h10, 1'b0);
        bus0.req_in = 8'h00; tick();
        check_all("coll_second4", 0, 3'd4, 1'b1, 8'h00, 1'b0);
        tick();
        check_all("coll_idle", 0, 3'd4, 1'b0, 8'h00, 1'b0);

        // Reset while the output is occupied.
        bus0.ready_in = 1'b0;
        bus0.req_in = 8'hFF; tick();
        bus0.req_in = 8'h00; tick();
        check_all("mid_busy", 0, 3'd7, 1'b1, 8'h7F, 1'b0);
        bus0.req_in = 8'hFF;
        do_reset();
        bus0.req_in = 8'h00; bus0.ready_in = 1'b1;
        check_all("mid_reset", 0, 3'd0, 1'b0, 8'h00, 1'b0);

        // Round-robin fairness: events 0 and 7 re-pulsed every cycle.
        bus1.req_in = 8'h81; bus1.ready_in = 1'b1;
        tick();
        check("rr_fill valid", 8'(bus1.valid_out), 8'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rr_code%0d", i), 8'(bus1.code_out), (i % 2 == 0) ? 8'd0 : 8'd7);
            check($sformatf("rr_valid%0d", i), 8'(bus1.valid_out), 8'd1);
        end
        bus1.req_in = 8'h00;

        // Random traffic on both instances against the model.
        bus0.req_in = 8'h00; bus1.req_in = 8'h00;
        do_reset();
        for (int m = 0; m < 2; m++) model_step(m, 8'h00, 1'b1, 1'b1);
        for (int c = 0; c < 600; c++) begin
            logic [7:0] r0, r1;
            logic       rd0, rd1, rs;
            r0  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            r1  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            rd0 = ($urandom_range(0, 3) != 0);
            rd1 = ($urandom_range(0, 3) != 0);
            rs  = ($urandom_range(0, 149) == 0);
            bus0.req_in = r0; bus0.ready_in = rd0;
            bus1.req_in = r1; bus1.ready_in = rd1;
            rst = rs;
            model_step(0, r0, rd0, rs);
            model_step(1, r1, rd1, rs);
            tick();
            check_all($sformatf("rnd%0d fixed", c), 0, m_code[0], m_valid[0], m_pend[0], m_ovf[0]);
            check_all($sformatf("rnd%0d rr", c),    1, m_code[1], m_valid[1], m_pend[1], m_ovf[1]);
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
